// File: rtl/mode_ctrl.sv
// Front-panel mode controller: debounces next/prev buttons, steps a pending
// mode with wrap-around, and commits it to mode_o only on a vsync rising edge.
module mode_ctrl #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 148500000,
  parameter int N_MODES      = 8,
  parameter int RESET_MODE   = 7
) (
  input  logic       vin_clk_i,
  input  logic       rst_ni,
  input  logic       btn_next_ni,
  input  logic       btn_prev_ni,
  input  logic       vin_vs_i,
  output logic [2:0] mode_o,
  output logic [2:0] pending_o,
  output logic       dirty_o,
  output logic       changed_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);

  localparam logic [2:0]    RST_M   = 3'(RESET_MODE);
  localparam logic [2:0]    MAX_M   = 3'(N_MODES - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LP_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] LP_SAT  = HW'(LONG_CYC);

  function automatic logic [2:0] wrap_inc(input logic [2:0] m);
    return (m == MAX_M) ? 3'd0 : m + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec(input logic [2:0] m);
    return (m == 3'd0) ? MAX_M : m - 3'd1;
  endfunction

  // Bit 0 carries the next button, bit 1 the prev button throughout.
  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    lvl_p1;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    db_p2, db_d_p2;
  logic [1:0]    press_p2;
  logic [HW-1:0] hold_cnt;
  logic          long_fire;
  logic          vs_q;
  logic          vs_rise;
  logic [2:0]    pend_nxt, mode_nxt;

  // Stage p0/p1: two-flop synchronizer, released (high) out of reset
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= {btn_prev_ni, btn_next_ni};
      sync_p1 <= sync_p0;
    end
  end

  assign lvl_p1 = ~sync_p1;

  // Stage p2: debounced levels; any return to the stable level restarts the count
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
      db_p2   <= 2'b00;
      db_d_p2 <= 2'b00;
    end else begin
      db_d_p2 <= db_p2;
      for (int b = 0; b < 2; b++) begin
        if (lvl_p1[b] == db_p2[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          db_p2[b]  <= ~db_p2[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + CW'(1);
        end
      end
    end
  end

  assign press_p2 = db_p2 & ~db_d_p2;

  // Hold counter saturates one past the fire point so a long hold fires once
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt <= '0;
    end else if (!db_p2[0]) begin
      hold_cnt <= '0;
    end else if (hold_cnt != LP_SAT) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign long_fire = db_p2[0] && (hold_cnt == LP_LAST);
  assign vs_rise   = vin_vs_i & ~vs_q;

  always_comb begin
    pend_nxt = pending_o;
    if (long_fire) begin
      pend_nxt = RST_M;
    end else if (press_p2 == 2'b11) begin
      pend_nxt = pending_o;
    end else if (press_p2[0]) begin
      pend_nxt = wrap_inc(pending_o);
    end else if (press_p2[1]) begin
      pend_nxt = wrap_dec(pending_o);
    end
  end

  // The commit takes the pre-update pending value, so a coincident press lands a frame later
  assign mode_nxt = vs_rise ? pending_o : mode_o;

  // Stage p3: registered outputs
  always_ff @(posedge vin_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q      <= 1'b0;
      pending_o <= RST_M;
      mode_o    <= RST_M;
      changed_o <= 1'b0;
      dirty_o   <= 1'b0;
    end else begin
      vs_q      <= vin_vs_i;
      pending_o <= pend_nxt;
      mode_o    <= mode_nxt;
      changed_o <= vs_rise && (pending_o != mode_o);
      dirty_o   <= (pend_nxt != mode_nxt);
    end
  end

endmodule

// File: tb/tb_mode_ctrl.sv
// Testbench for mode_ctrl: directed scenarios with fixed expectations plus a
// randomized run compared cycle by cycle against a behavioural reference.
module tb_mode_ctrl;

  localparam int DB = 4;
  localparam int LC = 20;
  localparam int NM = 8;
  localparam int RM = 7;

  logic       clk;
  logic       rst_n;
  logic       next_n, prev_n, vs;
  logic [2:0] mode, pend;
  logic       dirty, changed;

  int n_checks = 0;
  int n_fail   = 0;

  mode_ctrl #(
    .DEBOUNCE_CYC(DB),
    .LONG_CYC    (LC),
    .N_MODES     (NM),
    .RESET_MODE  (RM)
  ) dut (
    .vin_clk_i  (clk),
    .rst_ni     (rst_n),
    .btn_next_ni(next_n),
    .btn_prev_ni(prev_n),
    .vin_vs_i   (vs),
    .mode_o     (mode),
    .pending_o  (pend),
    .dirty_o    (dirty),
    .changed_o  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level is accepted after it has differed from the stable
  // level for DB consecutive cycles; a press is the cycle after acceptance;
  // long-press fires when next has been accepted-pressed for LC cycles.
  logic [1:0] m_d1, m_d2, m_db, m_dbo;
  int         m_run [2];
  int         m_hold;
  logic [2:0] m_pend, m_mode;
  logic       m_vsq, m_chg, m_dirty;

  logic [1:0] n_db, n_prs;
  int         n_run [2];
  int         n_hold;
  logic       n_fire, n_rise;
  logic [2:0] n_pend, n_mode;

  always_comb begin
    n_db = m_db;
    for (int b = 0; b < 2; b++) begin
      n_run[b] = 0;
      if ((~m_d2[b]) != m_db[b]) begin
        if (m_run[b] + 1 == DB) n_db[b] = ~m_d2[b];
        else n_run[b] = m_run[b] + 1;
      end
    end
    n_prs  = m_db & ~m_dbo;
    n_hold = m_db[0] ? m_hold + 1 : 0;
    n_fire = m_db[0] && (m_hold + 1 == LC);
    n_pend = m_pend;
    if (n_fire) n_pend = 3'(RM);
    else if (n_prs == 2'b01) n_pend = 3'((int'(m_pend) + 1) % NM);
    else if (n_prs == 2'b10) n_pend = 3'((int'(m_pend) + NM - 1) % NM);
    n_rise = vs && !m_vsq;
    n_mode = n_rise ? m_pend : m_mode;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 <= 2'b11; m_d2 <= 2'b11; m_db <= 2'b00; m_dbo <= 2'b00;
      m_run[0] <= 0; m_run[1] <= 0; m_hold <= 0;
      m_pend <= 3'(RM); m_mode <= 3'(RM);
      m_vsq <= 1'b0; m_chg <= 1'b0; m_dirty <= 1'b0;
    end else begin
      m_d1 <= {prev_n, next_n};
      m_d2 <= m_d1;
      m_db <= n_db;
      m_dbo <= m_db;
      m_run[0] <= n_run[0]; m_run[1] <= n_run[1];
      m_hold <= n_hold;
      m_pend <= n_pend;
      m_mode <= n_mode;
      m_vsq <= vs;
      m_chg <= n_rise && (m_pend != m_mode);
      m_dirty <= (n_pend != n_mode);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit nxt, input bit prv, input int hold);
    if (nxt) next_n = 1'b0;
    if (prv) prev_n = 1'b0;
    idle(hold);
    next_n = 1'b1;
    prev_n = 1'b1;
    idle(12);
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    idle(1);
    vs = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; next_n = 1'b1; prev_n = 1'b1; vs = 1'b0;
    idle(3);
    n_checks++;
    if (mode !== 3'd7 || pend !== 3'd7) begin
      n_fail++; $display("FAIL reset_hold: got mode=%0d pending=%0d, want 7/7", mode, pend);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (mode !== 3'd7 || pend !== 3'd7 || dirty !== 1'b0 || changed !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: got mode=%0d pending=%0d dirty=%0b changed=%0b, want 7/7/0/0",
                 mode, pend, dirty, changed);
      end
    end
    idle(1);
  endtask

  task automatic test_wrap_commit();
    next_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pend !== ((i == 7) ? 3'd0 : 3'd7)) begin
        n_fail++; $display("FAIL wrap_latency: cycle %0d got pending=%0d, want %0d", i, pend, (i == 7) ? 0 : 7);
      end
    end
    n_checks++;
    if (dirty !== 1'b1 || mode !== 3'd7) begin
      n_fail++; $display("FAIL wrap_dirty: got dirty=%0b mode=%0d, want 1/7", dirty, mode);
    end
    idle(1);
    next_n = 1'b1;
    idle(10);
    vs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mode !== 3'd0 || changed !== 1'b1 || dirty !== 1'b0) begin
      n_fail++; $display("FAIL commit: got mode=%0d changed=%0b dirty=%0b, want 0/1/0", mode, changed, dirty);
    end
    @(posedge clk);
    #1 vs = 1'b0;
    @(negedge clk);
    n_checks++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL changed_width: got changed=%0b, want 0", changed);
    end
    idle(1);
    press(1'b0, 1'b1, 8);
    n_checks++;
    if (pend !== 3'd7 || mode !== 3'd0 || dirty !== 1'b1) begin
      n_fail++; $display("FAIL prev_wrap: got pending=%0d mode=%0d dirty=%0b, want 7/0/1", pend, mode, dirty);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 40; k++) begin
      next_n = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pend !== 3'd7) begin
        n_fail++; $display("FAIL bounce_reject: cycle %0d got pending=%0d, want 7", k, pend);
      end
    end
    next_n = 1'b1;
    idle(12);
    press(1'b1, 1'b0, 5);
    n_checks++;
    if (pend !== 3'd0) begin
      n_fail++; $display("FAIL bounce_clean: got pending=%0d, want 0", pend);
    end
  endtask

  task automatic test_long_press();
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    vs_pulse();
    n_checks++;
    if (mode !== 3'd3 || pend !== 3'd3) begin
      n_fail++; $display("FAIL long_setup: got mode=%0d pending=%0d, want 3/3", mode, pend);
    end
    next_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pend !== ((i < 7) ? 3'd3 : (i < 26) ? 3'd4 : 3'd7)) begin
        n_fail++;
        $display("FAIL long_seq: cycle %0d got pending=%0d, want %0d", i, pend,
                 (i < 7) ? 3 : (i < 26) ? 4 : 7);
      end
    end
    idle(1);
    next_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_checks++;
      if (pend !== 3'd7 || mode !== 3'd3) begin
        n_fail++; $display("FAIL long_release: got pending=%0d mode=%0d, want 7/3", pend, mode);
      end
    end
    idle(1);
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1, 8);
    n_checks++;
    if (pend !== 3'd7 || dirty !== 1'b1) begin
      n_fail++; $display("FAIL both_press: got pending=%0d dirty=%0b, want 7/1", pend, dirty);
    end
    next_n = 1'b0;
    idle(6);
    vs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mode !== 3'd7 || changed !== 1'b1 || pend !== 3'd0 || dirty !== 1'b1) begin
      n_fail++;
      $display("FAIL vs_collide: got mode=%0d changed=%0b pending=%0d dirty=%0b, want 7/1/0/1",
               mode, changed, pend, dirty);
    end
    idle(1);
    vs = 1'b0;
    next_n = 1'b1;
    idle(12);
    vs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mode !== 3'd0 || changed !== 1'b1 || dirty !== 1'b0) begin
      n_fail++; $display("FAIL vs_followup: got mode=%0d changed=%0b dirty=%0b, want 0/1/0", mode, changed, dirty);
    end
    idle(1);
    vs = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid();
    press(1'b0, 1'b1, 8);
    next_n = 1'b0;
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mode !== 3'd7 || pend !== 3'd7 || dirty !== 1'b0 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_db: got mode=%0d pending=%0d dirty=%0b changed=%0b, want 7/7/0/0",
               mode, pend, dirty, changed);
    end
    idle(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pend !== ((i == 7) ? 3'd0 : 3'd7)) begin
        n_fail++; $display("FAIL rst_redebounce: cycle %0d got pending=%0d, want %0d", i, pend, (i == 7) ? 0 : 7);
      end
    end
    idle(8);
    n_checks++;
    if (dirty !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_hold_pre: got dirty=%0b, want 1", dirty);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mode !== 3'd7 || pend !== 3'd7 || dirty !== 1'b0 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got mode=%0d pending=%0d dirty=%0b changed=%0b, want 7/7/0/0",
               mode, pend, dirty, changed);
    end
    next_n = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(30);
    n_checks++;
    if (mode !== 3'd7 || pend !== 3'd7 || dirty !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got mode=%0d pending=%0d dirty=%0b, want 7/7/0", mode, pend, dirty);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      next_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      prev_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      len = (seg % 10 == 9) ? int'($urandom_range(20, 32)) : int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++) begin
        vs = ($urandom_range(0, 5) == 0);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (mode !== m_mode || pend !== m_pend || dirty !== m_dirty || changed !== m_chg) begin
          n_fail++;
          $display("FAIL random: seg %0d got mode=%0d pend=%0d dirty=%0b chg=%0b, want %0d/%0d/%0b/%0b",
                   seg, mode, pend, dirty, changed, m_mode, m_pend, m_dirty, m_chg);
        end
      end
    end
    next_n = 1'b1;
    prev_n = 1'b1;
    vs = 1'b0;
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap_commit();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
